axi_r_fsm: RTL and testbench
============================

Name: axi_r_fsm

Overview:
- Read-data (R) channel tracker that sits directly downstream of axi_ar_fsm.
- Snoops accepted AR handshakes into a per-ID table, then consumes R beats and counts them against arlen.
- On RLAST it frees the ID back to axi_ar_fsm via dealloc_req/dealloc_id and emits a per-transaction completion summary.
- Detects and flags protocol violations with sticky error bits.

Parameters:
- ADDR_WIDTH, 16, carried for package consistency; unused in datapath
- ID_WIDTH, 4, width of arid/rid
- ID_COUNT, 1<<ID_WIDTH, number of tracked IDs
- DATA_WIDTH, 32, width of rdata

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arvalid  in  1  AR valid (snooped)
- arready  in  1  AR ready (snooped)
- arid  in  ID_WIDTH  AR ID (snooped)
- arlen  in  8  AR burst length minus one (snooped)
- rvalid  in  1  R beat valid
- rready  out  1  R beat accept
- rid  in  ID_WIDTH  R beat ID
- rdata  in  DATA_WIDTH  R beat data
- rresp  in  2  R beat response
- rlast  in  1  last beat of burst
- rd_stall  in  1  consumer backpressure; forces rready low
- dealloc_req  out  1  one-cycle ID release pulse to axi_ar_fsm
- dealloc_id  out  ID_WIDTH  ID being released
- done_valid  out  1  one-cycle completion pulse
- done_id  out  ID_WIDTH  completed ID
- done_beats  out  9  beats received (1..256)
- done_resp  out  2  worst rresp seen in burst
- done_xor  out  DATA_WIDTH  XOR of all rdata beats in burst
- outstanding_cnt  out  ID_WIDTH+1  number of IDs currently outstanding
- err_flags  out  4  sticky: [0] unexpected rid, [1] length mismatch, [2] ID reuse, [3] non-OKAY resp
- err_clr  in  1  synchronous clear of err_flags

Behaviour:
- Reset (async assert): table cleared; every output is 0, including rready, dealloc_req, done_*, outstanding_cnt and err_flags. Reset asserted mid-burst discards all state and generates no dealloc.
- rready = !reset && !rd_stall, registered. A beat is accepted when rvalid && rready.
- Per-ID state machine: IDLE -> PENDING on AR handshake (stores arlen, clears beat count and xor) -> ACTIVE on first accepted beat -> IDLE on the accepted beat with rlast=1. A single-beat burst goes PENDING -> IDLE directly.
- Beat on a PENDING/ACTIVE ID:
  - beat count increments, saturating at 256
  - xor ^= rdata
  - worst_resp = max(worst_resp, rresp)
  - rresp != OKAY and != EXOKAY sets err[3]
- Beat with rlast=1 at edge N: entry returns to IDLE at edge N. During cycle N+1, dealloc_req=1 and done_valid=1 with dealloc_id = done_id = rid and the final beats/resp/xor; both pulses last one cycle. If the final count != arlen+1, err[1] is set and completion still occurs.
- Beat count reaching arlen+1 without rlast sets err[1]; counting continues until rlast.
- Beat on an IDLE ID: err[0] set, beat dropped, no dealloc, no completion.
- AR handshake on an ID that is not IDLE: err[2] set, the AR is ignored, and the existing entry is unchanged. This includes the same-cycle case of an AR on ID X while the rlast beat for X is accepted: completion wins and the AR is flagged.
- AR handshake and an R beat on different IDs in the same cycle: both are processed.
- outstanding_cnt counts non-IDLE entries and updates at the same edge as the state change.
- err_clr clears err_flags. If an error occurs in the same cycle as err_clr, the error bit wins.

Decomposition:
- Package axi_spy_pkg:
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
  - id_state_t enum: IDLE, PENDING, ACTIVE
  - err bit index constants
  - id_entry_t struct: state, len[7:0], beats[8:0], resp, xor
- Sub-module axi_r_id_table: ID_COUNT-entry register array with one write-on-AR port, one read-modify-write-on-R port, and the outstanding counter.

Test Plan:
- Reset, then AR id=0 arlen=8, then 9 beats rid=0 rresp=OKAY with rlast on beat 9 -> one cycle after the last beat: dealloc_req=1, dealloc_id=0, done_beats=9, done_resp=0, err_flags=0, outstanding_cnt 1->0.
- AR id=1 arlen=4 and AR id=2 arlen=2; R beats interleaved 2,1,2,1,2(last),1,1,1(last) -> completions for id 2 (3 beats) then id 1 (5 beats); done_xor matches the XOR of each ID's data.
- R beat rid=5 with no AR -> err[0]=1, no dealloc. Then err_clr -> err_flags=0.
- AR id=3 arlen=4; rlast on beat 3 -> err[1]=1, dealloc id 3, done_beats=3. Repeat with 6 beats -> err[1], done_beats=6.
- AR id=4 arlen=1, beats with rresp=2 then 0 -> done_resp=2, err[3]=1. A second AR id=4 before rlast -> err[2]=1, entry intact.
- rd_stall=1 for 3 cycles mid-burst -> rready=0 and no beats counted. Reset mid-burst -> all outputs 0 and no dealloc.

Source files
------------

// File: rtl/axi_spy_pkg.sv
// Shared types for the AXI read-side trackers: response codes, per-ID state,
// table entry layout and error-bit positions.
package axi_spy_pkg;

  localparam int DATA_W    = 32;
  localparam int ERR_RID   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_REUSE = 2;
  localparam int ERR_RESP  = 3;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } id_state_t;

  // Reset value of every field is zero, so a cleared entry is IDLE.
  typedef struct packed {
    id_state_t         state;
    logic [7:0]        len;
    logic [8:0]        beats;
    resp_t             resp;
    logic [DATA_W-1:0] dxor;
  } id_entry_t;

  function automatic resp_t worst_resp(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [8:0] sat_inc(input logic [8:0] n);
    return (n == 9'd256) ? n : n + 9'd1;
  endfunction

endpackage

// File: rtl/axi_r_id_table.sv
// Per-ID transaction table: AR-side allocate port, R-side read-modify-write
// port, and a running count of entries that are not IDLE.
module axi_r_id_table
  import axi_spy_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int ID_COUNT = 1 << ID_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ar_we,
  input  logic [ID_WIDTH-1:0] ar_id,
  input  logic [7:0]          ar_len,
  output id_state_t           ar_state,
  input  logic [ID_WIDTH-1:0] r_id,
  output id_entry_t           r_entry,
  input  logic                r_we,
  input  id_entry_t           r_wdata,
  output logic [ID_WIDTH:0]   outstanding_cnt
);

  id_entry_t tbl [ID_COUNT];
  logic      retire;

  assign ar_state = tbl[ar_id].state;
  assign r_entry  = tbl[r_id];
  assign retire   = r_we && (r_wdata.state == IDLE);

  // The top only allocates into IDLE entries and only updates busy ones,
  // so the two write ports never target the same entry in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ID_COUNT; i++) tbl[i] <= '0;
      outstanding_cnt <= '0;
    end else begin
      if (ar_we)
        tbl[ar_id] <= '{state: PENDING, len: ar_len, beats: '0, resp: OKAY, dxor: '0};
      if (r_we)
        tbl[r_id] <= r_wdata;
      case ({ar_we, retire})
        2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
        2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_r_fsm.sv
// R-channel tracker: snoops AR handshakes, counts R beats per ID, releases the
// ID on RLAST with a one-cycle completion summary, and keeps sticky error bits.
module axi_r_fsm
  import axi_spy_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int ID_COUNT   = 1 << ID_WIDTH,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [7:0]            arlen,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rd_stall,
  output logic                  dealloc_req,
  output logic [ID_WIDTH-1:0]   dealloc_id,
  output logic                  done_valid,
  output logic [ID_WIDTH-1:0]   done_id,
  output logic [8:0]            done_beats,
  output logic [1:0]            done_resp,
  output logic [DATA_WIDTH-1:0] done_xor,
  output logic [ID_WIDTH:0]     outstanding_cnt,
  output logic [3:0]            err_flags,
  input  logic                  err_clr
);

  logic      ar_hs, beat, ar_we, r_we, r_busy, fin;
  id_state_t ar_state;
  id_entry_t r_entry, r_wdata;
  resp_t     beat_resp;
  logic [8:0] nbeats, target;
  logic [3:0] err_set;

  assign ar_hs     = arvalid && arready;
  assign beat      = rvalid && rready;
  assign beat_resp = resp_t'(rresp);
  assign r_busy    = r_entry.state != IDLE;
  assign nbeats    = sat_inc(r_entry.beats);
  assign target    = {1'b0, r_entry.len} + 9'd1;
  assign r_we      = beat && r_busy;
  assign ar_we     = ar_hs && (ar_state == IDLE);
  assign fin       = r_we && rlast;

  // Next value of the entry addressed by rid; PENDING->IDLE covers 1-beat bursts.
  always_comb begin
    r_wdata       = r_entry;
    r_wdata.state = rlast ? IDLE : ACTIVE;
    r_wdata.beats = nbeats;
    r_wdata.resp  = worst_resp(r_entry.resp, beat_resp);
    r_wdata.dxor  = r_entry.dxor ^ DATA_W'(rdata);
  end

  // AR reuse is judged on the pre-edge state, so an AR racing its own RLAST is flagged.
  always_comb begin
    err_set            = '0;
    err_set[ERR_RID]   = beat && !r_busy;
    err_set[ERR_LEN]   = r_we && (rlast ? (nbeats != target) : (nbeats == target));
    err_set[ERR_REUSE] = ar_hs && (ar_state != IDLE);
    err_set[ERR_RESP]  = r_we && ((beat_resp == SLVERR) || (beat_resp == DECERR));
  end

  axi_r_id_table #(
    .ID_WIDTH (ID_WIDTH),
    .ID_COUNT (ID_COUNT)
  ) u_table (
    .clk             (clk),
    .reset           (reset),
    .ar_we           (ar_we),
    .ar_id           (arid),
    .ar_len          (arlen),
    .ar_state        (ar_state),
    .r_id            (rid),
    .r_entry         (r_entry),
    .r_we            (r_we),
    .r_wdata         (r_wdata),
    .outstanding_cnt (outstanding_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rready      <= 1'b0;
      dealloc_req <= 1'b0;
      dealloc_id  <= '0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_beats  <= '0;
      done_resp   <= '0;
      done_xor    <= '0;
      err_flags   <= '0;
    end else begin
      rready      <= !rd_stall;
      dealloc_req <= fin;
      dealloc_id  <= fin ? rid : '0;
      done_valid  <= fin;
      done_id     <= fin ? rid : '0;
      done_beats  <= fin ? nbeats : '0;
      done_resp   <= fin ? r_wdata.resp : OKAY;
      done_xor    <= fin ? DATA_WIDTH'(r_wdata.dxor) : '0;
      err_flags   <= (err_clr ? 4'd0 : err_flags) | err_set;
    end
  end

endmodule

// File: tb/tb_axi_r_fsm.sv
// Bench for axi_r_fsm: directed vector table, hand-written corner sequences and
// a random phase, all checked against a per-ID array model every cycle.
module tb_axi_r_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arready, rvalid, rready, rlast, rd_stall, err_clr;
  logic [3:0]  arid, rid, dealloc_id, done_id, err_flags;
  logic [7:0]  arlen;
  logic [31:0] rdata, done_xor;
  logic [1:0]  rresp, done_resp;
  logic        dealloc_req, done_valid;
  logic [8:0]  done_beats;
  logic [4:0]  outstanding_cnt;

  axi_r_fsm #(.ADDR_WIDTH(16), .ID_WIDTH(4), .ID_COUNT(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .arvalid(arvalid), .arready(arready), .arid(arid),
    .arlen(arlen), .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rd_stall(rd_stall), .dealloc_req(dealloc_req),
    .dealloc_id(dealloc_id), .done_valid(done_valid), .done_id(done_id),
    .done_beats(done_beats), .done_resp(done_resp), .done_xor(done_xor),
    .outstanding_cnt(outstanding_cnt), .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain per-ID bookkeeping plus the expected registered outputs.
  bit          m_busy [16];
  int          m_len [16], m_cnt [16], m_worst [16];
  logic [31:0] m_xor [16];
  bit          e_rready, e_dv;
  int          e_id, e_beats, e_resp, e_cnt;
  logic [31:0] e_xor;
  logic [3:0]  e_err;

  typedef struct {
    bit arv; int aid; int alen;
    bit rv; int id; logic [31:0] d; int resp; bit last; bit clr;
    bit xd; int xid; int xbeats; int xresp; int xcnt; int xerr;
  } vec_t;
  vec_t vq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_busy[k] = 0; m_len[k] = 0; m_cnt[k] = 0; m_worst[k] = 0; m_xor[k] = '0;
    end
    e_rready = 0; e_dv = 0; e_id = 0; e_beats = 0; e_resp = 0; e_cnt = 0;
    e_xor = '0; e_err = '0;
  endtask

  task automatic model_edge();
    logic [3:0] nerr;
    bit take, ar, clash;
    int i;
    nerr  = '0;
    take  = rvalid && e_rready;
    ar    = arvalid && arready;
    clash = ar && m_busy[arid];
    e_dv = 0; e_id = 0; e_beats = 0; e_resp = 0; e_xor = '0;
    if (take) begin
      i = int'(rid);
      if (!m_busy[i]) nerr[0] = 1'b1;
      else begin
        if (m_cnt[i] < 256) m_cnt[i]++;
        m_xor[i] ^= rdata;
        if (int'(rresp) > m_worst[i]) m_worst[i] = int'(rresp);
        if (rresp >= 2) nerr[3] = 1'b1;
        if (rlast) begin
          if (m_cnt[i] != m_len[i] + 1) nerr[1] = 1'b1;
          e_dv = 1; e_id = i; e_beats = m_cnt[i]; e_resp = m_worst[i]; e_xor = m_xor[i];
          m_busy[i] = 0;
        end else if (m_cnt[i] == m_len[i] + 1) nerr[1] = 1'b1;
      end
    end
    if (clash) nerr[2] = 1'b1;
    else if (ar) begin
      i = int'(arid);
      m_busy[i] = 1; m_len[i] = int'(arlen); m_cnt[i] = 0; m_worst[i] = 0; m_xor[i] = '0;
    end
    e_err    = (err_clr ? 4'd0 : e_err) | nerr;
    e_rready = !rd_stall;
    e_cnt    = 0;
    for (int k = 0; k < 16; k++) e_cnt += int'(m_busy[k]);
  endtask

  task automatic check_all();
    chk("rready",          64'(rready),          64'(e_rready));
    chk("dealloc_req",     64'(dealloc_req),     64'(e_dv));
    chk("dealloc_id",      64'(dealloc_id),      64'(e_id));
    chk("done_valid",      64'(done_valid),      64'(e_dv));
    chk("done_id",         64'(done_id),         64'(e_id));
    chk("done_beats",      64'(done_beats),      64'(e_beats));
    chk("done_resp",       64'(done_resp),       64'(e_resp));
    chk("done_xor",        64'(done_xor),        64'(e_xor));
    chk("outstanding_cnt", 64'(outstanding_cnt), 64'(e_cnt));
    chk("err_flags",       64'(err_flags),       64'(e_err));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    arvalid = 0; arready = 0; arid = '0; arlen = '0; rvalid = 0; rid = '0;
    rdata = '0; rresp = '0; rlast = 0; rd_stall = 0; err_clr = 0;
  endtask

  task automatic ar_in(input int id, input int len);
    arvalid = 1; arready = 1; arid = 4'(id); arlen = 8'(len);
  endtask

  task automatic r_in(input int id, input logic [31:0] d, input int resp, input bit last);
    rvalid = 1; rid = 4'(id); rdata = d; rresp = 2'(resp); rlast = last;
  endtask

  function automatic vec_t mk(bit arv, int aid, int alen, bit rv, int id, logic [31:0] d,
                              int resp, bit last, bit clr, bit xd, int xid, int xbeats,
                              int xresp, int xcnt, int xerr);
    vec_t t;
    t.arv = arv; t.aid = aid; t.alen = alen; t.rv = rv; t.id = id; t.d = d;
    t.resp = resp; t.last = last; t.clr = clr; t.xd = xd; t.xid = xid;
    t.xbeats = xbeats; t.xresp = xresp; t.xcnt = xcnt; t.xerr = xerr;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int n);
    idle_in();
    if (t.arv) ar_in(t.aid, t.alen);
    if (t.rv) r_in(t.id, t.d, t.resp, t.last);
    err_clr = t.clr;
    tick();
    chk($sformatf("vec%0d dealloc_req", n), 64'(dealloc_req), 64'(t.xd));
    if (t.xd) begin
      chk($sformatf("vec%0d dealloc_id", n), 64'(dealloc_id), 64'(t.xid));
      chk($sformatf("vec%0d done_beats", n), 64'(done_beats), 64'(t.xbeats));
      chk($sformatf("vec%0d done_resp", n),  64'(done_resp),  64'(t.xresp));
    end
    chk($sformatf("vec%0d outstanding", n), 64'(outstanding_cnt), 64'(t.xcnt));
    chk($sformatf("vec%0d err_flags", n),   64'(err_flags),       64'(t.xerr));
  endtask

  initial begin
    int ids [8]  = '{2, 1, 2, 1, 2, 1, 1, 1};
    bit lsts [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    int cnts [8] = '{2, 2, 2, 2, 1, 1, 1, 0};
    int pick, q [$];

    // Directed table covering the main completion, interleave and error cases.
    vq.push_back(mk(1,0,8, 0,0,0,0,0, 0, 0,0,0,0, 1,0));
    for (int k = 1; k <= 9; k++)
      vq.push_back(mk(0,0,0, 1,0,32'hA000_0000 + k,0,k == 9, 0, k == 9,0,9,0, (k == 9) ? 0 : 1, 0));
    vq.push_back(mk(0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 0,0));
    vq.push_back(mk(1,1,4, 0,0,0,0,0, 0, 0,0,0,0, 1,0));
    vq.push_back(mk(1,2,2, 0,0,0,0,0, 0, 0,0,0,0, 2,0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0,0,0, 1,ids[k],32'h1234_0000 ^ (k * 32'h0101_0101),0,lsts[k], 0,
                      lsts[k],ids[k],(ids[k] == 2) ? 3 : 5,0, cnts[k],0));
    vq.push_back(mk(0,0,0, 1,5,32'hDEAD,0,1, 0, 0,0,0,0, 0,1));
    vq.push_back(mk(0,0,0, 0,0,0,0,0, 1, 0,0,0,0, 0,0));
    vq.push_back(mk(1,3,4, 0,0,0,0,0, 0, 0,0,0,0, 1,0));
    for (int k = 1; k <= 3; k++)
      vq.push_back(mk(0,0,0, 1,3,32'h30 + k,0,k == 3, 0, k == 3,3,3,0, (k == 3) ? 0 : 1, (k == 3) ? 2 : 0));
    vq.push_back(mk(0,0,0, 0,0,0,0,0, 1, 0,0,0,0, 0,0));
    vq.push_back(mk(1,3,4, 0,0,0,0,0, 0, 0,0,0,0, 1,0));
    for (int k = 1; k <= 6; k++)
      vq.push_back(mk(0,0,0, 1,3,32'h60 + k,0,k == 6, 0, k == 6,3,6,0, (k == 6) ? 0 : 1, (k >= 5) ? 2 : 0));
    vq.push_back(mk(0,0,0, 0,0,0,0,0, 1, 0,0,0,0, 0,0));
    vq.push_back(mk(1,4,1, 0,0,0,0,0, 0, 0,0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 1,4,32'h4444,2,0, 0, 0,0,0,0, 1,8));
    vq.push_back(mk(1,4,7, 0,0,0,0,0, 0, 0,0,0,0, 1,12));
    vq.push_back(mk(0,0,0, 1,4,32'h5555,0,1, 0, 1,4,2,2, 0,12));
    vq.push_back(mk(0,0,0, 0,0,0,0,0, 1, 0,0,0,0, 0,0));

    idle_in();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    tick();

    foreach (vq[n]) apply(vq[n], n);

    // Backpressure: three cycles with rready low, offered beats must not count.
    idle_in(); ar_in(6, 3); tick();
    idle_in(); r_in(6, 32'h6001, 0, 0); tick();
    idle_in(); rd_stall = 1; tick();
    chk("stall rready0", 64'(rready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      idle_in(); rd_stall = 1; r_in(6, 32'hBAD0 + k, 0, 1); tick();
      chk("stall rready", 64'(rready), 64'd0);
    end
    idle_in(); tick();
    for (int k = 2; k <= 4; k++) begin
      idle_in(); r_in(6, 32'h6000 + k, 0, k == 4); tick();
    end
    chk("stall done_beats", 64'(done_beats), 64'd4);
    chk("stall dealloc", 64'(dealloc_req), 64'd1);
    chk("stall err", 64'(err_flags), 64'd0);

    // Reset in the middle of a burst drops everything without a dealloc.
    idle_in(); ar_in(7, 3); tick();
    idle_in(); r_in(7, 32'h7001, 0, 0); tick();
    idle_in(); r_in(9, 32'h7002, 0, 0); tick();
    chk("pre-reset err", 64'(err_flags), 64'd1);
    idle_in();
    #2 reset = 1'b1;
    #1;
    chk("async rst rready", 64'(rready), 64'd0);
    chk("async rst cnt", 64'(outstanding_cnt), 64'd0);
    chk("async rst err", 64'(err_flags), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    tick();
    chk("post-rst dealloc", 64'(dealloc_req), 64'd0);
    idle_in(); r_in(7, 32'h7003, 0, 1); tick();
    chk("post-rst stale id", 64'(err_flags), 64'd1);
    chk("post-rst no dealloc", 64'(dealloc_req), 64'd0);

    // AR racing its own RLAST, AR and R on different IDs, and clear-vs-set.
    idle_in(); err_clr = 1; tick();
    idle_in(); ar_in(8, 0); tick();
    idle_in(); ar_in(8, 0); r_in(8, 32'h8888, 0, 1); tick();
    chk("race dealloc_id", 64'(dealloc_id), 64'd8);
    chk("race err", 64'(err_flags), 64'd4);
    idle_in(); tick();
    chk("race cnt", 64'(outstanding_cnt), 64'd0);
    idle_in(); ar_in(9, 0); tick();
    idle_in(); ar_in(10, 1); r_in(9, 32'h9999, 1, 1); tick();
    chk("dual dealloc_id", 64'(dealloc_id), 64'd9);
    chk("dual cnt", 64'(outstanding_cnt), 64'd1);
    idle_in(); err_clr = 1; r_in(11, 32'h1, 0, 0); tick();
    chk("clr vs set", 64'(err_flags), 64'd1);
    for (int k = 0; k < 2; k++) begin
      idle_in(); r_in(10, 32'hA0A0 + k, 0, k == 1); tick();
    end
    chk("dual2 done_beats", 64'(done_beats), 64'd2);

    // 256-beat burst overrun by one: count saturates at 256.
    idle_in(); err_clr = 1; tick();
    idle_in(); ar_in(12, 255); tick();
    for (int k = 1; k <= 257; k++) begin
      idle_in(); r_in(12, 32'(k * 7), 0, k == 257); tick();
    end
    chk("sat done_beats", 64'(done_beats), 64'd256);
    chk("sat dealloc_id", 64'(dealloc_id), 64'd12);
    chk("sat err", 64'(err_flags), 64'd2);

    // Random traffic against the model.
    idle_in(); err_clr = 1; tick();
    for (int c = 0; c < 2000; c++) begin
      idle_in();
      arvalid  = ($urandom_range(0, 3) == 0);
      arready  = 1'($urandom_range(0, 1));
      arid     = 4'($urandom_range(0, 15));
      arlen    = 8'($urandom_range(0, 4));
      rd_stall = ($urandom_range(0, 7) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      rvalid   = ($urandom_range(0, 2) != 0);
      q.delete();
      for (int k = 0; k < 16; k++) if (m_busy[k]) q.push_back(k);
      pick = (q.size() != 0 && $urandom_range(0, 7) != 0) ?
             q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, 15));
      rid   = 4'(pick);
      rdata = $urandom;
      rresp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if (m_busy[pick])
        rlast = (m_cnt[pick] + 1 >= m_len[pick] + 1) ? ($urandom_range(0, 9) != 0)
                                                     : ($urandom_range(0, 15) == 0);
      else
        rlast = 1'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
